// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default bus widths and the highest program memory address.
package fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 5;
    localparam int DEFAULT_INSTR_W = 8;
    localparam int MAX_ADDR        = (1 << DEFAULT_ADDR_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_instr_reg.sv
// Instruction register: captures the fetched word and the address it came
// from on a load strobe, holds them otherwise, clears on async reset.
module instr_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  pc_q;

    // Latch word and source address together so decode always sees a matching pair
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end

    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage between the PC and decode. Reads program memory at
// the current PC over req/ack, latches the word, hands it to decode over
// valid/ready and turns decode jumps into PC load strobes with a flush.
// Optional feature macro: FETCH_WRAP_HALT_EN stops fetching after the PC
// wraps until decode issues a jump.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  pc_val,
    input  logic               pc_wrapped,
    output logic               pc_inc,
    output logic               pc_overwrite,
    output logic [ADDR_W-1:0]  pc_new_val,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               halted
);

`ifdef FETCH_WRAP_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    fetch_state_t state_q, state_d;
    logic         irLoad;
    logic         wrapToHalt;

    // Without the halt feature the wrap flag never redirects the FSM
    assign wrapToHalt = HALT_EN & pc_wrapped;

    // State register; async reset abandons any in-flight request at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and IR load; a jump overrides everything and discards any ack
    always_comb begin
        state_d = state_q;
        irLoad  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    irLoad  = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (ir_ready) begin
                    state_d = wrapToHalt ? HALT : REQ;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (jump_req) begin
            irLoad  = 1'b0;
            state_d = REQ;
        end
    end

    assign mem_req      = (state_q == REQ);
    assign mem_addr     = mem_req ? pc_val : '0;
    assign pc_inc       = irLoad;
    assign ir_valid     = (state_q == VALID);
    assign pc_overwrite = jump_req & rstn;
    assign pc_new_val   = pc_overwrite ? jump_target : '0;
    assign halted       = HALT_EN & (state_q == HALT);

    instr_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) instrReg (
        .clk   (clk),
        .rstn  (rstn),
        .load_i(irLoad),
        .data_i(mem_rdata),
        .pc_i  (pc_val),
        .data_o(ir_data),
        .pc_o  (ir_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch/decode stream.
module tb_instr_fetch;

    localparam int AW = 5;
    localparam int IW = 8;

`ifdef FETCH_WRAP_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] pcVal;
    logic          pcWrapped;
    logic          pc_inc;
    logic          pc_overwrite;
    logic [AW-1:0] pc_new_val;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          ir_valid;
    logic          ir_ready;
    logic [IW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic          jump_req;
    logic [AW-1:0] jump_target;
    logic          halted;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_val      (pcVal),
        .pc_wrapped  (pcWrapped),
        .pc_inc      (pc_inc),
        .pc_overwrite(pc_overwrite),
        .pc_new_val  (pc_new_val),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .jump_req    (jump_req),
        .jump_target (jump_target),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Program counter environment: load wins over increment, wrap flag set when stepping past the top
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcVal     <= '0;
            pcWrapped <= 1'b0;
        end else if (pc_overwrite) begin
            pcVal     <= pc_new_val;
            pcWrapped <= 1'b0;
        end else if (pc_inc) begin
            pcVal     <= pcVal + 1'b1;
            pcWrapped <= (pcVal == 5'd31);
        end
    end

    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
        return {3'b000, a} + 8'h10;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; jump_req = 1'b0; jump_target = '0;
        mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        #2;
        checks++;
        if ({pc_inc, pc_overwrite, pc_new_val, mem_req, mem_addr, ir_valid, ir_data, ir_pc, halted} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {pc_inc, pc_overwrite, pc_new_val, mem_req, mem_addr, ir_valid, ir_data, ir_pc, halted});
        end
        cycle(); cycle();
        rstn = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle_req: got %b required 0", mem_req);
        end
        cycle();
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd0}) begin
            errors++; $display("[TB] FAIL first_req: got %b required %b", {mem_req, mem_addr}, {1'b1, 5'd0});
        end
    endtask

    task automatic test_sequential();
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; mem_rdata = memWord(mem_addr);
            #1;
            checks++;
            if ({mem_req, mem_addr, pc_inc, ir_valid} !== {1'b1, 5'(i), 1'b1, 1'b0}) begin
                errors++; $display("[TB] FAIL seq_req[%0d]: got %b required %b", i,
                                   {mem_req, mem_addr, pc_inc, ir_valid}, {1'b1, 5'(i), 1'b1, 1'b0});
            end
            cycle();
            mem_ack = 1'b0;
            #1;
            checks++;
            if ({ir_valid, ir_data, ir_pc, mem_req, pc_inc} !== {1'b1, 8'(8'h10 + i), 5'(i), 1'b0, 1'b0}) begin
                errors++; $display("[TB] FAIL seq_valid[%0d]: got %h required %h", i,
                                   {ir_valid, ir_data, ir_pc, mem_req, pc_inc}, {1'b1, 8'(8'h10 + i), 5'(i), 1'b0, 1'b0});
            end
            cycle();
        end
    endtask

    task automatic test_stall();
        mem_ack = 1'b1; mem_rdata = memWord(mem_addr); ir_ready = 1'b0;
        #1;
        cycle();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({ir_valid, ir_data, ir_pc, mem_req, pc_inc} !== {1'b1, 8'h13, 5'd3, 1'b0, 1'b0}) begin
                errors++; $display("[TB] FAIL stall[%0d]: got %h required %h", i,
                                   {ir_valid, ir_data, ir_pc, mem_req, pc_inc}, {1'b1, 8'h13, 5'd3, 1'b0, 1'b0});
            end
            cycle();
        end
        ir_ready = 1'b1;
        #1;
        cycle();
    endtask

    task automatic test_jump();
        mem_ack = 1'b1; mem_rdata = memWord(mem_addr);
        jump_req = 1'b1; jump_target = 5'h1A;
        #1;
        checks++;
        if ({pc_overwrite, pc_new_val, pc_inc, mem_req} !== {1'b1, 5'h1A, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL jump_strobe: got %b required %b",
                               {pc_overwrite, pc_new_val, pc_inc, mem_req}, {1'b1, 5'h1A, 1'b0, 1'b1});
        end
        cycle();
        jump_req = 1'b0; jump_target = '0; mem_ack = 1'b0;
        #1;
        checks++;
        if ({ir_valid, mem_req, mem_addr, ir_data, ir_pc, pc_overwrite, pc_new_val} !==
            {1'b0, 1'b1, 5'h1A, 8'h13, 5'd3, 1'b0, 5'd0}) begin
            errors++; $display("[TB] FAIL jump_flush: got %h required %h",
                               {ir_valid, mem_req, mem_addr, ir_data, ir_pc, pc_overwrite, pc_new_val},
                               {1'b0, 1'b1, 5'h1A, 8'h13, 5'd3, 1'b0, 5'd0});
        end
        mem_ack = 1'b1; mem_rdata = memWord(mem_addr);
        cycle();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h2A, 5'h1A}) begin
            errors++; $display("[TB] FAIL jump_fetch: got %h required %h",
                               {ir_valid, ir_data, ir_pc}, {1'b1, 8'h2A, 5'h1A});
        end
        cycle();
    endtask

    task automatic test_wrap();
        jump_req = 1'b1; jump_target = 5'd31;
        #1;
        cycle();
        jump_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd31}) begin
            errors++; $display("[TB] FAIL wrap_addr: got %b required %b", {mem_req, mem_addr}, {1'b1, 5'd31});
        end
        mem_ack = 1'b1; mem_rdata = memWord(mem_addr);
        cycle();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({ir_valid, ir_pc, ir_data} !== {1'b1, 5'd31, 8'h2F}) begin
            errors++; $display("[TB] FAIL wrap_valid: got %h required %h", {ir_valid, ir_pc, ir_data}, {1'b1, 5'd31, 8'h2F});
        end
        cycle();
        #1;
`ifdef FETCH_WRAP_HALT_EN
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({halted, mem_req, ir_valid} !== 3'b100) begin
                errors++; $display("[TB] FAIL wrap_halt[%0d]: got %b required 100", i, {halted, mem_req, ir_valid});
            end
            cycle();
        end
        jump_req = 1'b1; jump_target = 5'd3;
        #1;
        checks++;
        if ({pc_overwrite, pc_new_val} !== {1'b1, 5'd3}) begin
            errors++; $display("[TB] FAIL halt_jump: got %b required %b", {pc_overwrite, pc_new_val}, {1'b1, 5'd3});
        end
        cycle();
        jump_req = 1'b0;
        #1;
        checks++;
        if ({halted, mem_req, mem_addr} !== {1'b0, 1'b1, 5'd3}) begin
            errors++; $display("[TB] FAIL halt_resume: got %b required %b", {halted, mem_req, mem_addr}, {1'b0, 1'b1, 5'd3});
        end
`else
        checks++;
        if ({halted, mem_req, mem_addr} !== {1'b0, 1'b1, 5'd0}) begin
            errors++; $display("[TB] FAIL wrap_continue: got %b required %b", {halted, mem_req, mem_addr}, {1'b0, 1'b1, 5'd0});
        end
        jump_req = 1'b1; jump_target = 5'd3;
        #1;
        cycle();
        jump_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd3}) begin
            errors++; $display("[TB] FAIL wrap_jump3: got %b required %b", {mem_req, mem_addr}, {1'b1, 5'd3});
        end
`endif
    endtask

    task automatic test_ack_delay();
        int incCount;
        incCount = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b0;
            #1;
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 5'd3}) begin
                errors++; $display("[TB] FAIL delay_hold[%0d]: got %b required %b", i, {mem_req, mem_addr}, {1'b1, 5'd3});
            end
            incCount += int'(pc_inc);
            cycle();
        end
        mem_ack = 1'b1; mem_rdata = memWord(mem_addr);
        #1;
        incCount += int'(pc_inc);
        cycle();
        mem_ack = 1'b0;
        #1;
        incCount += int'(pc_inc);
        checks++;
        if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h13, 5'd3}) begin
            errors++; $display("[TB] FAIL delay_data: got %h required %h", {ir_valid, ir_data, ir_pc}, {1'b1, 8'h13, 5'd3});
        end
        checks++;
        if (incCount !== 1) begin
            errors++; $display("[TB] FAIL delay_inc_count: got %0d required 1", incCount);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        jump_req = 1'b1; jump_target = 5'd7;
        #1;
        cycle();
        jump_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd7}) begin
            errors++; $display("[TB] FAIL mid_pre: got %b required %b", {mem_req, mem_addr}, {1'b1, 5'd7});
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({pc_inc, pc_overwrite, pc_new_val, mem_req, mem_addr, ir_valid, ir_data, ir_pc, halted} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %h required 0",
                     {pc_inc, pc_overwrite, pc_new_val, mem_req, mem_addr, ir_valid, ir_data, ir_pc, halted});
        end
        cycle();
        rstn = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_idle: got %b required 0", mem_req);
        end
        cycle();
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd0}) begin
            errors++; $display("[TB] FAIL mid_restart: got %b required %b", {mem_req, mem_addr}, {1'b1, 5'd0});
        end
    endtask

    // Stream model: decode must see consecutive addresses, restarting at each jump target
    task automatic test_random();
        logic [AW-1:0] expAddr;
        logic          expHalted;
        logic          prevJump;
        logic          consumedTop;
        expAddr = '0; expHalted = 1'b0; prevJump = 1'b0;
        for (int n = 0; n < 800; n++) begin
            ir_ready    = 1'($urandom_range(0, 1));
            jump_req    = ($urandom_range(0, 11) == 0);
            jump_target = 5'($urandom);
            mem_ack     = mem_req && ($urandom_range(0, 2) != 0);
            mem_rdata   = memWord(mem_addr);
            #1;
            consumedTop = 1'b0;
            if (prevJump) begin
                checks++;
                if (ir_valid !== 1'b0) begin
                    errors++; $display("[TB] FAIL rnd_flush[%0d]: got %b required 0", n, ir_valid);
                end
            end
            checks++;
            if ({halted, halted && mem_req} !== {expHalted, 1'b0}) begin
                errors++; $display("[TB] FAIL rnd_halted[%0d]: got %b required %b", n, {halted, halted && mem_req}, {expHalted, 1'b0});
            end
            if (ir_valid && ir_ready) begin
                checks++;
                if ({ir_pc, ir_data} !== {expAddr, memWord(expAddr)}) begin
                    errors++; $display("[TB] FAIL rnd_consume[%0d]: got %h required %h", n, {ir_pc, ir_data}, {expAddr, memWord(expAddr)});
                end
                consumedTop = (expAddr == 5'd31);
                expAddr = expAddr + 1'b1;
            end
            if (mem_ack && !jump_req) begin
                checks++;
                if ({pc_inc, mem_addr} !== {1'b1, expAddr}) begin
                    errors++; $display("[TB] FAIL rnd_fetch[%0d]: got %b required %b", n, {pc_inc, mem_addr}, {1'b1, expAddr});
                end
            end else begin
                checks++;
                if (pc_inc !== 1'b0) begin
                    errors++; $display("[TB] FAIL rnd_no_inc[%0d]: got %b required 0", n, pc_inc);
                end
            end
            if (jump_req) begin
                checks++;
                if ({pc_overwrite, pc_new_val} !== {1'b1, jump_target}) begin
                    errors++; $display("[TB] FAIL rnd_jump[%0d]: got %b required %b", n, {pc_overwrite, pc_new_val}, {1'b1, jump_target});
                end
                expAddr   = jump_target;
                expHalted = 1'b0;
            end else begin
                checks++;
                if ({pc_overwrite, pc_new_val} !== 6'd0) begin
                    errors++; $display("[TB] FAIL rnd_no_jump[%0d]: got %b required 0", n, {pc_overwrite, pc_new_val});
                end
                if (consumedTop && HALT_BUILD) expHalted = 1'b1;
            end
            prevJump = jump_req;
            cycle();
        end
        jump_req = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] starting instr_fetch bench (halt build = %0d)", HALT_BUILD);
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_wrap();
        test_ack_delay();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
